// File: rtl/sample_rate_ctrl.sv
// sample_rate_ctrl: sequences sampling for the logic sniffer capture path.
// Holds the host-programmed rate divider and sample-count limit, arms on
// start, waits for a trigger and then issues one-cycle sample_en strobes at
// the programmed rate until the limit is reached or the host stops the run.
// Optional feature macro: SAMPLE_RATE_CTRL_TRIG_EN. When it is defined, an
// ARMED state waits for trigger before running. When it is undefined,
// trigger is ignored and start enters RUN directly.
module sample_rate_ctrl #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_nsamples,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    input  logic             trigger,
    output logic             sample_en,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_r;
    logic [CNT_W-1:0] nsamp_r;
    logic [DIV_W-1:0] presc;

    logic             cfg_accept;
    logic             strobe_due;
    logic [CNT_W-1:0] cnt_next;
    logic             limit_hit;

    // Config is only taken while no run is in flight, so shadows stay stable mid-run
    assign cfg_ready  = (state == IDLE) || (state == DONE);
    assign cfg_accept = cfg_valid && cfg_ready;

    assign busy = (state == ARMED) || (state == RUN);
    assign done = (state == DONE);

    // The prescaler has counted a full period when it matches the divider
    assign strobe_due = (presc == div_r);
    assign cnt_next   = sample_cnt + 1'b1;
    assign limit_hit  = (nsamp_r != '0) && (cnt_next == nsamp_r);

`ifndef SAMPLE_RATE_CTRL_TRIG_EN
    logic unused_trigger;
    assign unused_trigger = trigger;
`endif

    // Shadow registers for divider and sample limit, loaded on an accepted config
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            div_r   <= '0;
            nsamp_r <= '0;
        end else if (cfg_accept) begin
            div_r   <= cfg_div;
            nsamp_r <= cfg_nsamples;
        end
    end

    // Run sequencer: state, prescaler, strobe and sample counter (stop > start > trigger > limit)
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            sample_en  <= 1'b0;
            sample_cnt <= '0;
        end else begin
            sample_en <= 1'b0;
            if (stop) begin
                state <= IDLE;
            end else if (start && cfg_ready) begin
                sample_cnt <= '0;
`ifdef SAMPLE_RATE_CTRL_TRIG_EN
                state      <= ARMED;
`else
                state      <= RUN;
                presc      <= '0;
`endif
            end else if ((state == ARMED) && trigger) begin
`ifdef SAMPLE_RATE_CTRL_TRIG_EN
                state <= RUN;
                presc <= '0;
`endif
            end else if (state == RUN) begin
                if (strobe_due) begin
                    presc      <= '0;
                    sample_en  <= 1'b1;
                    sample_cnt <= cnt_next;
                    if (limit_hit) begin
                        state <= DONE;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end else if (cfg_accept && (state == DONE)) begin
                state <= IDLE;
            end
        end
    end

endmodule
